mar: RTL and testbench
======================

Name: mar

Overview:
- Memory Address Register for the 16-bit microcontroller datapath.
- Captures an address from the shared internal bus when enabled and holds it stable on the memory address lines until the next load.
- Also provides auto-increment for sequential access and a region decode of the held address, so memory/IO selects come straight from registered state.

Parameters:
- ADDR_W, 16, width of the bus, the register and the output.
- RESET_ADDR, 16'h0000, value loaded on reset.
- ROM_TOP, 16'h3FFF, highest address decoded as ROM (ROM = 0x0000..ROM_TOP).
- IO_BASE, 16'hFF00, lowest address decoded as IO (IO = IO_BASE..all-ones); RAM is everything between.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- MAR_Address_from_BUS  in  ADDR_W  address value driven on the internal bus.
- MAR_En  in  1  load enable; captures the bus on the next rising edge.
- MAR_Inc  in  1  increment enable; adds 1 to the held address on the next rising edge.
- MAR_Address_Out  out  ADDR_W  registered address to memory.
- MAR_Sel_ROM  out  1  held address is in the ROM region.
- MAR_Sel_RAM  out  1  held address is in the RAM region.
- MAR_Sel_IO  out  1  held address is in the IO region.
- MAR_Wrap  out  1  one-cycle pulse: the last increment wrapped from all-ones to 0.

Behaviour:
- One clock domain. Reset is synchronous and active-high, named rst. Clock is named clk.
- Priority at each rising clk edge: rst > MAR_En > MAR_Inc > hold.
- rst=1:
  - MAR_Address_Out <= RESET_ADDR (0x0000).
  - MAR_Wrap <= 0.
  - MAR_En and MAR_Inc are ignored that cycle.
  - Reset takes effect mid-operation on the next edge, regardless of pending load or increment.
- MAR_En=1 (rst=0):
  - MAR_Address_Out <= MAR_Address_from_BUS.
  - Latency 1 clock: bus value visible on the output after the edge.
  - MAR_Wrap <= 0.
  - A simultaneous MAR_Inc is ignored; the loaded value is not incremented.
- MAR_Inc=1, MAR_En=0, rst=0:
  - MAR_Address_Out <= MAR_Address_Out + 1, modulo 2^ADDR_W.
  - At all-ones the next value is 0 and MAR_Wrap <= 1 for exactly that cycle; otherwise MAR_Wrap <= 0.
- No enables asserted: output holds its value; MAR_Wrap <= 0.
- Bus changes while MAR_En=0 have no effect on the output.
- Output is purely registered; no combinational path from bus to MAR_Address_Out.
- Region selects:
  - Decoded combinationally from the registered MAR_Address_Out only; exactly one select is high at all times.
  - ROM: addr <= ROM_TOP.
  - IO: addr >= IO_BASE.
  - RAM: otherwise.
  - Boundaries are inclusive as stated: 0x3FFF is ROM, 0x4000 is RAM, 0xFEFF is RAM, 0xFF00 is IO.
- Parameter legality: ROM_TOP < IO_BASE. Otherwise behaviour is undefined; flag with a simulation-only assertion.
- After reset with defaults: output 0x0000, MAR_Sel_ROM=1, others 0, MAR_Wrap=0.

Test Plan:
- Load: bus=0x00CF, MAR_En pulsed one cycle -> MAR_Address_Out=0x00CF from the next edge; holds when MAR_En=0 and bus changes to 0x1234.
- Reset priority: output 0x00CF, assert rst for 2 cycles with MAR_En toggling and bus=0x00CF -> output 0x0000 after the first edge; stays 0 while rst=1. Deassert rst, bus=0x00AD, MAR_En=1 -> output 0x00AD.
- Increment and wrap:
  - Load 0xFFFE, MAR_Inc 2 cycles -> 0xFFFF, then 0x0000.
  - MAR_Wrap=1 only in the cycle showing 0x0000; 0 in all other cycles.
- Load/increment conflict: MAR_En=1, MAR_Inc=1, bus=0x0100 -> output exactly 0x0100 (no +1).
- Region boundaries: load 0x3FFF, 0x4000, 0xFEFF, 0xFF00 in turn -> selects ROM, RAM, RAM, IO respectively, one-hot each cycle.
- Increment across boundary: load 0x3FFF, MAR_Inc one cycle -> output 0x4000; MAR_Sel_ROM falls and MAR_Sel_RAM rises in the same cycle.

Source files
------------

// File: rtl/mar.sv
// -----------------------------------------------------------------------------
// mar : Memory Address Register for the 16-bit microcontroller datapath.
//
// Captures an address from the shared internal bus on MAR_En, optionally
// steps it by one on MAR_Inc, and holds it stable on the memory address lines.
// The ROM/RAM/IO region selects are decoded from the registered address only,
// so they never glitch with bus activity.
//
// Ports:
//   clk                   in   system clock, rising edge active
//   rst                   in   synchronous active-high reset
//   MAR_Address_from_BUS  in   [ADDR_W] address driven on the internal bus
//   MAR_En                in   load enable (wins over MAR_Inc)
//   MAR_Inc               in   increment enable
//   MAR_Address_Out       out  [ADDR_W] registered address to memory
//   MAR_Sel_ROM           out  held address is in 0 .. ROM_TOP
//   MAR_Sel_RAM           out  held address is between ROM and IO
//   MAR_Sel_IO            out  held address is in IO_BASE .. all-ones
//   MAR_Wrap              out  one-cycle pulse: last increment wrapped to 0
// -----------------------------------------------------------------------------
module mar #(
    parameter int                 ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = 16'h0000,
    parameter logic [ADDR_W-1:0]  ROM_TOP    = 16'h3FFF,
    parameter logic [ADDR_W-1:0]  IO_BASE    = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] MAR_Address_from_BUS,
    input  logic              MAR_En,
    input  logic              MAR_Inc,
    output logic [ADDR_W-1:0] MAR_Address_Out,
    output logic              MAR_Sel_ROM,
    output logic              MAR_Sel_RAM,
    output logic              MAR_Sel_IO,
    output logic              MAR_Wrap
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr;
    logic              wrap;
    logic              at_top;

    // Incrementing from all-ones is the only case that wraps to zero.
    assign at_top = &addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= RESET_ADDR;
            wrap <= 1'b0;
        end else if (MAR_En) begin
            addr <= MAR_Address_from_BUS;
            wrap <= 1'b0;
        end else if (MAR_Inc) begin
            addr <= addr + ONE;
            wrap <= at_top;
        end else begin
            wrap <= 1'b0;
        end
    end

    logic in_rom;
    logic in_io;

    // ROM_TOP < IO_BASE guarantees the two ranges are disjoint, so RAM as
    // "neither" keeps the selects one-hot.
    assign in_rom = (addr <= ROM_TOP);
    assign in_io  = (addr >= IO_BASE);

    assign MAR_Address_Out = addr;
    assign MAR_Wrap        = wrap;
    assign MAR_Sel_ROM     = in_rom;
    assign MAR_Sel_IO      = in_io;
    assign MAR_Sel_RAM     = !in_rom && !in_io;

    // Overlapping ROM and IO windows would make the decode ambiguous.
    always @(posedge clk) begin
        assert (ROM_TOP < IO_BASE)
            else $error("mar: ROM_TOP must be below IO_BASE");
    end

endmodule

// File: tb/tb_mar.sv
module tb_mar;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        en;
    logic        inc;
    logic [15:0] addr_out;
    logic        sel_rom;
    logic        sel_ram;
    logic        sel_io;
    logic        wrap;

    mar dut (
        .clk                  (clk),
        .rst                  (rst),
        .MAR_Address_from_BUS (bus),
        .MAR_En               (en),
        .MAR_Inc              (inc),
        .MAR_Address_Out      (addr_out),
        .MAR_Sel_ROM          (sel_rom),
        .MAR_Sel_RAM          (sel_ram),
        .MAR_Sel_IO           (sel_io),
        .MAR_Wrap             (wrap)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] ROM = 3'b100;
    localparam logic [2:0] RAM = 3'b010;
    localparam logic [2:0] IO  = 3'b001;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  sel;
        logic        wrap;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check_out();
        exp_t        x;
        logic [2:0]  sel_obs;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_underflow observed empty queue expected an entry");
            return;
        end
        x = exp_q.pop_front();
        sel_obs = {sel_rom, sel_ram, sel_io};

        vectors++;
        assert (addr_out === x.addr) else begin
            miscompares++;
            $error("FAIL %s_addr observed %h expected %h", x.tag, addr_out, x.addr);
        end
        vectors++;
        assert (sel_obs === x.sel) else begin
            miscompares++;
            $error("FAIL %s_sel observed %b expected %b", x.tag, sel_obs, x.sel);
        end
        vectors++;
        assert (wrap === x.wrap) else begin
            miscompares++;
            $error("FAIL %s_wrap observed %b expected %b", x.tag, wrap, x.wrap);
        end
        vectors++;
        assert ($onehot(sel_obs)) else begin
            miscompares++;
            $error("FAIL %s_onehot observed %b expected one-hot", x.tag, sel_obs);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then
    // sample #1 after the rising edge.
    task automatic step(input logic r, input logic e, input logic i,
                        input logic [15:0] b, input logic [15:0] ea,
                        input logic [2:0] es, input logic ew, input string tag);
        exp_t x;
        rst = r;
        en  = e;
        inc = i;
        bus = b;
        x.addr = ea;
        x.sel  = es;
        x.wrap = ew;
        x.tag  = tag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        inc = 1'b0;
        bus = 16'h0000;

        //    rst  en   inc  bus       addr      sel  wrap
        step(1'b1, 1'b1, 1'b0, 16'h5555, 16'h0000, ROM, 1'b0, "reset");
        step(1'b0, 1'b1, 1'b0, 16'h00CF, 16'h00CF, ROM, 1'b0, "load_cf");
        step(1'b0, 1'b0, 1'b0, 16'h1234, 16'h00CF, ROM, 1'b0, "hold_bus_change");
        step(1'b0, 1'b0, 1'b0, 16'h1234, 16'h00CF, ROM, 1'b0, "hold_again");
        step(1'b1, 1'b1, 1'b0, 16'h00CF, 16'h0000, ROM, 1'b0, "rst_over_load");
        step(1'b1, 1'b0, 1'b1, 16'h00CF, 16'h0000, ROM, 1'b0, "rst_held");
        step(1'b0, 1'b1, 1'b0, 16'h00AD, 16'h00AD, ROM, 1'b0, "load_ad");

        step(1'b0, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, IO,  1'b0, "load_fffe");
        step(1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, IO,  1'b0, "inc_ffff");
        step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, ROM, 1'b1, "inc_wrap");
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, ROM, 1'b0, "wrap_clears");

        step(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0100, ROM, 1'b0, "load_beats_inc");
        step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0101, ROM, 1'b0, "inc_plain");

        step(1'b0, 1'b1, 1'b0, 16'h3FFF, 16'h3FFF, ROM, 1'b0, "rom_top");
        step(1'b0, 1'b1, 1'b0, 16'h4000, 16'h4000, RAM, 1'b0, "ram_bottom");
        step(1'b0, 1'b1, 1'b0, 16'hFEFF, 16'hFEFF, RAM, 1'b0, "ram_top");
        step(1'b0, 1'b1, 1'b0, 16'hFF00, 16'hFF00, IO,  1'b0, "io_base");

        step(1'b0, 1'b1, 1'b0, 16'h3FFF, 16'h3FFF, ROM, 1'b0, "load_3fff");
        step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000, RAM, 1'b0, "inc_rom_to_ram");
        step(1'b0, 1'b1, 1'b0, 16'hFEFF, 16'hFEFF, RAM, 1'b0, "load_feff");
        step(1'b0, 1'b0, 1'b1, 16'h0000, 16'hFF00, IO,  1'b0, "inc_ram_to_io");

        step(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, IO,  1'b0, "load_ffff_no_wrap");
        step(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, ROM, 1'b0, "rst_beats_wrap");
        step(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0001, ROM, 1'b0, "inc_after_rst");

        vectors++;
        assert (exp_q.size() === 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain observed %0d left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
